// File: rtl/plot_arbiter.sv
// plot_arbiter: round-robin arbiter that shares the single pixel-write port
// of vga_adapter among N_REQ game-logic requesters using a req/ack
// handshake, so every request produces exactly one plotted pixel.
// Optional full-screen clear engine, compiled in when the macro
// PLOT_ARBITER_CLEAR_EN is defined; without it the block is a pure arbiter
// and clear_busy/clear_done are tied low.
// All outputs are registered; reset is synchronous and active-high.
module plot_arbiter #(
  parameter int         N_REQ        = 4,
  parameter int         X_MAX        = 159,
  parameter int         Y_MAX        = 119,
  parameter logic [2:0] CLEAR_COLOUR = 3'b000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_REQ-1:0]   req,
  input  logic [8*N_REQ-1:0] req_x,
  input  logic [7*N_REQ-1:0] req_y,
  input  logic [3*N_REQ-1:0] req_colour,
  output logic [N_REQ-1:0]   ack,
  input  logic               clear_start,
  output logic               clear_busy,
  output logic               clear_done,
  output logic [7:0]         x_out,
  output logic [6:0]         y_out,
  output logic [2:0]         colour,
  output logic               plot
);

  localparam int RR_W = $clog2(N_REQ);

  // Round-robin pointer: the requester searched first on the next grant.
  logic [RR_W-1:0] rr, rr_d;

  // Next values for the registered outputs.
  logic [7:0]       x_d;
  logic [6:0]       y_d;
  logic [2:0]       colour_d;
  logic             plot_d;
  logic [N_REQ-1:0] ack_d;

  // Arbitration result for the current cycle.
  logic            grant_valid;
  logic [RR_W-1:0] grant_idx;
  logic [RR_W-1:0] idx;
  logic            arb_en;

  // Per-requester views of the packed data buses.
  logic [7:0] x_slot      [N_REQ];
  logic [6:0] y_slot      [N_REQ];
  logic [2:0] colour_slot [N_REQ];

  for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
    assign x_slot[g]      = req_x[8*g +: 8];
    assign y_slot[g]      = req_y[7*g +: 7];
    assign colour_slot[g] = req_colour[3*g +: 3];
  end

`ifdef PLOT_ARBITER_CLEAR_EN
  typedef enum logic {ARB, CLEAR} state_t;

  localparam logic [7:0] X_LAST = 8'(X_MAX);
  localparam logic [6:0] Y_LAST = 7'(Y_MAX);

  state_t     state, state_d;
  logic [7:0] cx, cx_d;
  logic [6:0] cy, cy_d;
  logic       busy_d, done_d;
`else
  // Clear engine absent: clear inputs and sweep parameters have no effect.
  logic unused_clear_cfg;
  assign unused_clear_cfg = clear_start ^ (^CLEAR_COLOUR) ^ (X_MAX == Y_MAX);
  assign clear_busy = 1'b0;
  assign clear_done = 1'b0;
`endif

  // Round-robin search: first eligible requester at or above rr, wrapping.
  // The ack mask stops a re-grant while the requester is still dropping req.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    idx         = '0;
    // Walk downward so the lowest offset from rr is the one that sticks.
    for (int off = N_REQ - 1; off >= 0; off--) begin
      idx = RR_W'((int'(rr) + off) % N_REQ);
      if (req[idx] && !ack[idx]) begin
        grant_valid = 1'b1;
        grant_idx   = idx;
      end
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    rr_d     = rr;
    x_d      = x_out;
    y_d      = y_out;
    colour_d = colour;
    plot_d   = 1'b0;
    ack_d    = '0;
    arb_en   = 1'b1;
`ifdef PLOT_ARBITER_CLEAR_EN
    state_d = state;
    cx_d    = cx;
    cy_d    = cy;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    case (state)
      ARB: begin
        // Clear wins over any simultaneous request; pixel (0,0) goes out next.
        if (clear_start) begin
          state_d  = CLEAR;
          cx_d     = '0;
          cy_d     = '0;
          x_d      = '0;
          y_d      = '0;
          colour_d = CLEAR_COLOUR;
          plot_d   = 1'b1;
          busy_d   = 1'b1;
          arb_en   = 1'b0;
        end
      end
      CLEAR: begin
        if (cx == X_LAST && cy == Y_LAST) begin
          // Last pixel is on the port now: finish, and arbitrate this cycle.
          state_d = ARB;
          done_d  = 1'b1;
        end else begin
          arb_en   = 1'b0;
          busy_d   = 1'b1;
          plot_d   = 1'b1;
          colour_d = CLEAR_COLOUR;
          if (cx == X_LAST) begin
            cx_d = '0;
            cy_d = cy + 7'd1;
          end else begin
            cx_d = cx + 8'd1;
          end
          x_d = cx_d;
          y_d = cy_d;
        end
      end
      default: state_d = ARB;
    endcase
`endif
    if (arb_en && grant_valid) begin
      x_d            = x_slot[grant_idx];
      y_d            = y_slot[grant_idx];
      colour_d       = colour_slot[grant_idx];
      plot_d         = 1'b1;
      ack_d          = '0;
      ack_d[grant_idx] = 1'b1;
      // Explicit wrap keeps rr in range for non-power-of-two N_REQ.
      rr_d = (grant_idx == RR_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

  // State, pointer and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      rr     <= '0;
      x_out  <= '0;
      y_out  <= '0;
      colour <= '0;
      plot   <= 1'b0;
      ack    <= '0;
`ifdef PLOT_ARBITER_CLEAR_EN
      state      <= ARB;
      cx         <= '0;
      cy         <= '0;
      clear_busy <= 1'b0;
      clear_done <= 1'b0;
`endif
    end else begin
      rr     <= rr_d;
      x_out  <= x_d;
      y_out  <= y_d;
      colour <= colour_d;
      plot   <= plot_d;
      ack    <= ack_d;
`ifdef PLOT_ARBITER_CLEAR_EN
      state      <= state_d;
      cx         <= cx_d;
      cy         <= cy_d;
      clear_busy <= busy_d;
      clear_done <= done_d;
`endif
    end
  end

endmodule

// File: tb/tb_plot_arbiter.sv
// tb_plot_arbiter: directed, table-driven bench for plot_arbiter (N_REQ=4).
// Inputs change and outputs are sampled on the falling clock edge.
// Clear-engine sequences run when PLOT_ARBITER_CLEAR_EN is defined; otherwise
// the bench checks that clear_start is ignored.
module tb_plot_arbiter;

  localparam int N_REQ = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic [N_REQ-1:0] req;
  logic [8*N_REQ-1:0] req_x;
  logic [7*N_REQ-1:0] req_y;
  logic [3*N_REQ-1:0] req_colour;
  logic [N_REQ-1:0] ack;
  logic             clear_start;
  logic             clear_busy;
  logic             clear_done;
  logic [7:0]       x_out;
  logic [6:0]       y_out;
  logic [2:0]       colour;
  logic             plot;

  int n_vec = 0;
  int n_bad = 0;

  plot_arbiter #(
    .N_REQ(N_REQ), .X_MAX(159), .Y_MAX(119), .CLEAR_COLOUR(3'b000)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .req_x(req_x), .req_y(req_y),
    .req_colour(req_colour), .ack(ack), .clear_start(clear_start),
    .clear_busy(clear_busy), .clear_done(clear_done), .x_out(x_out),
    .y_out(y_out), .colour(colour), .plot(plot)
  );

  always #5 clk = ~clk;

  // Global time limit so the run always ends.
  initial begin
    #3_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] actual,
                       input logic [31:0] expected);
    n_vec++;
    if (actual !== expected) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)",
               name, actual, actual, expected, expected);
    end
  endtask

  task automatic check_port(input string tag, input logic e_plot,
                            input logic [3:0] e_ack, input logic [7:0] e_x,
                            input logic [6:0] e_y, input logic [2:0] e_col);
    check({tag, ".plot"},   32'(plot),   32'(e_plot));
    check({tag, ".ack"},    32'(ack),    32'(e_ack));
    check({tag, ".x"},      32'(x_out),  32'(e_x));
    check({tag, ".y"},      32'(y_out),  32'(e_y));
    check({tag, ".colour"}, 32'(colour), 32'(e_col));
  endtask

  typedef struct {
    logic [3:0] req;
    logic       e_plot;
    logic [3:0] e_ack;
    logic [7:0] e_x;
    logic [6:0] e_y;
    logic [2:0] e_col;
  } vec_t;

  vec_t vecs [16];

  initial begin
    // Requester data: 0=(5,1,001) 1=(30,2,011) 2=(10,20,010) 3=(159,119,111)
    req_x      = {8'd159, 8'd10, 8'd30, 8'd5};
    req_y      = {7'd119, 7'd20, 7'd2,  7'd1};
    req_colour = {3'b111, 3'b010, 3'b011, 3'b001};

    // Expected values worked by hand from rr and the previous ack.
    vecs[0]  = '{4'b1111, 1'b1, 4'b0001, 8'd5,   7'd1,   3'b001};
    vecs[1]  = '{4'b1111, 1'b1, 4'b0010, 8'd30,  7'd2,   3'b011};
    vecs[2]  = '{4'b1111, 1'b1, 4'b0100, 8'd10,  7'd20,  3'b010};
    vecs[3]  = '{4'b1111, 1'b1, 4'b1000, 8'd159, 7'd119, 3'b111};
    vecs[4]  = '{4'b1111, 1'b1, 4'b0001, 8'd5,   7'd1,   3'b001};
    vecs[5]  = '{4'b0000, 1'b0, 4'b0000, 8'd5,   7'd1,   3'b001};
    vecs[6]  = '{4'b0100, 1'b1, 4'b0100, 8'd10,  7'd20,  3'b010};
    vecs[7]  = '{4'b0100, 1'b0, 4'b0000, 8'd10,  7'd20,  3'b010};
    vecs[8]  = '{4'b0000, 1'b0, 4'b0000, 8'd10,  7'd20,  3'b010};
    vecs[9]  = '{4'b0011, 1'b1, 4'b0001, 8'd5,   7'd1,   3'b001};
    vecs[10] = '{4'b0011, 1'b1, 4'b0010, 8'd30,  7'd2,   3'b011};
    vecs[11] = '{4'b0001, 1'b1, 4'b0001, 8'd5,   7'd1,   3'b001};
    vecs[12] = '{4'b1000, 1'b1, 4'b1000, 8'd159, 7'd119, 3'b111};
    vecs[13] = '{4'b1010, 1'b1, 4'b0010, 8'd30,  7'd2,   3'b011};
    vecs[14] = '{4'b1010, 1'b1, 4'b1000, 8'd159, 7'd119, 3'b111};
    vecs[15] = '{4'b0000, 1'b0, 4'b0000, 8'd159, 7'd119, 3'b111};

    // Reset held for two cycles with every requester active.
    reset       = 1'b1;
    req         = 4'b1111;
    clear_start = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      check_port($sformatf("reset%0d", c), 1'b0, 4'b0000, 8'd0, 7'd0, 3'd0);
      check($sformatf("reset%0d.busy", c), 32'(clear_busy), 32'd0);
      check($sformatf("reset%0d.done", c), 32'(clear_done), 32'd0);
    end
    reset = 1'b0;
    req   = 4'b0000;
    @(negedge clk);
    check_port("idle", 1'b0, 4'b0000, 8'd0, 7'd0, 3'd0);

    // Table: first vector checks that the first grant goes to requester 0.
    for (int v = 0; v < 16; v++) begin
      req = vecs[v].req;
      @(negedge clk);
      check_port($sformatf("v%0d", v), vecs[v].e_plot, vecs[v].e_ack,
                 vecs[v].e_x, vecs[v].e_y, vecs[v].e_col);
    end

`ifdef PLOT_ARBITER_CLEAR_EN
    begin
      int bad_pix;
      int first_bad;
      bit found;

      // Clear priority: clear_start and req[1] in the same cycle.
      bad_pix   = 0;
      first_bad = -1;
      clear_start = 1'b1;
      req         = 4'b0010;
      for (int p = 0; p < 19200; p++) begin
        @(negedge clk);
        if (p == 0)   clear_start = 1'b0;
        if (p == 100) clear_start = 1'b1;   // must be ignored mid-sweep
        if (p == 101) clear_start = 1'b0;
        if (plot !== 1'b1 || colour !== 3'b000 || clear_busy !== 1'b1 ||
            ack !== 4'b0000 || clear_done !== 1'b0 ||
            x_out !== 8'(p % 160) || y_out !== 7'(p / 160)) begin
          if (first_bad < 0) first_bad = p;
          bad_pix++;
        end
      end
      if (first_bad >= 0)
        $display("first bad sweep pixel index %0d", first_bad);
      check("sweep.bad_pixels", 32'(bad_pix), 32'd0);

      // Cycle after the last pixel: done pulse plus the stalled grant.
      @(negedge clk);
      check("done.pulse", 32'(clear_done), 32'd1);
      check("done.busy",  32'(clear_busy), 32'd0);
      check_port("done", 1'b1, 4'b0010, 8'd30, 7'd2, 3'b011);
      req = 4'b0000;
      @(negedge clk);
      check("after_done.pulse", 32'(clear_done), 32'd0);
      check("after_done.plot",  32'(plot),       32'd0);

      // Reset in the middle of a sweep at pixel (50,30).
      clear_start = 1'b1;
      found = 1'b0;
      for (int c = 0; c < 6000 && !found; c++) begin
        @(negedge clk);
        clear_start = 1'b0;
        if (x_out == 8'd50 && y_out == 7'd30) found = 1'b1;
      end
      check("midclear.reached", 32'(found), 32'd1);
      reset = 1'b1;
      @(negedge clk);
      check_port("midclear.reset", 1'b0, 4'b0000, 8'd0, 7'd0, 3'd0);
      check("midclear.busy", 32'(clear_busy), 32'd0);
      check("midclear.done", 32'(clear_done), 32'd0);
      reset = 1'b0;
      for (int c = 0; c < 3; c++) begin
        @(negedge clk);
        check($sformatf("postreset%0d.done", c), 32'(clear_done), 32'd0);
        check($sformatf("postreset%0d.busy", c), 32'(clear_busy), 32'd0);
        check($sformatf("postreset%0d.plot", c), 32'(plot),       32'd0);
      end
      // rr was 2 before reset; a reset pointer picks requester 0 first.
      req = 4'b1001;
      @(negedge clk);
      check_port("postreset.grant", 1'b1, 4'b0001, 8'd5, 7'd1, 3'b001);
      req = 4'b0000;
      @(negedge clk);
    end
`else
    // No clear engine: clear_start is ignored and requests keep flowing.
    clear_start = 1'b1;
    req         = 4'b0100;
    @(negedge clk);
    clear_start = 1'b0;
    check_port("noclr.grant", 1'b1, 4'b0100, 8'd10, 7'd20, 3'b010);
    check("noclr.busy", 32'(clear_busy), 32'd0);
    check("noclr.done", 32'(clear_done), 32'd0);
    req = 4'b0000;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("noclr%0d.busy", c), 32'(clear_busy), 32'd0);
      check($sformatf("noclr%0d.done", c), 32'(clear_done), 32'd0);
      check($sformatf("noclr%0d.plot", c), 32'(plot),       32'd0);
    end
    req = 4'b1000;
    @(negedge clk);
    check_port("noclr.grant3", 1'b1, 4'b1000, 8'd159, 7'd119, 3'b111);
    req = 4'b0000;
    @(negedge clk);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/plot_arbiter.md
# plot_arbiter

Shares the single pixel-write port of `vga_adapter` (160x120, 3-bit colour) among several game-logic requesters, such as head draw, tail erase, food draw and score overlay. Uses round-robin arbitration with a req/ack handshake, so each request produces exactly one plotted pixel. An optional full-screen clear engine sweeps every pixel to a fixed colour for game start and game over. Sits between the game datapath/control and `vga_adapter`, driving its `x`, `y`, `colour` and `plot` inputs directly.

## Interface
Parameters:
- `N_REQ`, 4: number of requesters (2..8).
- `X_MAX`, 159: last column of the clear sweep.
- `Y_MAX`, 119: last row of the clear sweep.
- `CLEAR_COLOUR`, 3'b000: colour written by the clear sweep.

Ports:
- `clk`  in  1: system clock (CLOCK_50 domain); one clock only.
- `reset`  in  1: synchronous, active-high reset.
- `req`  in  N_REQ: per-requester pixel request; level, held until ack.
- `req_x`  in  8*N_REQ: packed x; requester i uses bits [8i+7:8i].
- `req_y`  in  7*N_REQ: packed y; requester i uses bits [7i+6:7i].
- `req_colour`  in  3*N_REQ: packed colour; requester i uses bits [3i+2:3i].
- `ack`  out  N_REQ: one-hot; a one-cycle pulse means the request was plotted this cycle.
- `clear_start`  in  1: single-cycle pulse that starts the clear sweep.
- `clear_busy`  out  1: high while the sweep runs.
- `clear_done`  out  1: one-cycle pulse after the last swept pixel.
- `x_out`  out  8: pixel x to `vga_adapter`.
- `y_out`  out  7: pixel y to `vga_adapter`.
- `colour`  out  3: pixel colour to `vga_adapter`.
- `plot`  out  1: write enable to `vga_adapter`.

## Operation
- FSM states:
  - `ARB`, the reset state.
  - `CLEAR`.
- `ARB` eligibility: requester i is eligible when `req[i]=1` and `ack[i]=0`. Masking by `ack[i]` prevents a double grant while the requester drops `req` in the cycle after its ack.
- `ARB` selection: search from the round-robin pointer `rr` upward with wrap at N_REQ; the first eligible i wins.
- On a grant to i:
  - register `x_out`/`y_out`/`colour` from slice i;
  - set `plot=1` and `ack=1<<i`;
  - set `rr <= (i+1) mod N_REQ`.
- No eligible requester: `plot=0`, `ack=0`; `x_out`/`y_out`/`colour` hold their last values; `rr` unchanged.
- `clear_start=1` in `ARB`:
  - enter `CLEAR` with sweep counters `cx=0`, `cy=0`;
  - clear has priority over any simultaneous `req`, which is not acked that cycle.
- `CLEAR`, each cycle:
  - `x_out=cx`, `y_out=cy`, `colour=CLEAR_COLOUR`, `plot=1`;
  - step `cx` 0..X_MAX, then wrap to 0 and increment `cy`;
  - after pixel (X_MAX, Y_MAX), return to `ARB` and pulse `clear_done`.
- In `CLEAR`:
  - `clear_busy=1`;
  - `ack` stays 0, so requests stall and wait with data held;
  - `clear_start` is ignored.
- Widths:
  - `cx` is 8-bit and `cy` is 7-bit; each compares against its parameter and never overflows its register.
  - `rr` is `$clog2(N_REQ)` bits, with an explicit wrap for non-power-of-two N_REQ.

## Timing
- All outputs are registered.
- Reset values:
  - `x_out=0`, `y_out=0`, `colour=0`, `plot=0`, `ack=0`;
  - `clear_busy=0`, `clear_done=0`;
  - `rr=0`, state `ARB`.
- Reset asserted mid-sweep aborts the sweep: no `clear_done`, and on the next edge the block is in the reset values.
- Grant latency: `req[i]` sampled high at edge k gives `plot` and `ack[i]` high during cycle k+1, on the same cycle as each other.
- Handshake: the requester holds `req` and its data stable until it sees `ack`. It may re-assert `req` with new data in the cycle after `ack`. The earliest second grant to the same requester is two cycles after the first; other requesters may fill the gap.
- Throughput: one pixel per cycle when at least two requesters are active.
- Sweep timing:
  - `clear_start` at edge k gives pixel (0,0) in cycle k+1;
  - `clear_busy` is high from cycle k+1 through the cycle of the last pixel: (X_MAX+1)*(Y_MAX+1) = 19200 cycles at the default parameters;
  - `clear_done` pulses in the cycle after the last pixel;
  - a requester can be acked in that same cycle.

## Configuration
- Macro `PLOT_ARBITER_CLEAR_EN`.
- Defined: the clear engine and `CLEAR` state are compiled in, as described above.
- Undefined:
  - no `CLEAR` state, no sweep counters;
  - `clear_start` is ignored;
  - `clear_busy` and `clear_done` are tied to 0;
  - the block is a pure round-robin arbiter.

## Test plan
- Reset:
  - assert `reset` for 2 cycles while `req=4'b1111` -> all outputs 0, no ack;
  - first grant after release goes to requester 0.
- Single request: `req[2]=1` with x=10, y=20, colour=3'b010 -> one cycle later `plot=1`, `x_out=10`, `y_out=20`, `colour=3'b010`, `ack=4'b0100`; no second ack while `req` drops.
- Round-robin: `req=4'b1111` held with distinct data -> acks in order 0,1,2,3,0 on consecutive cycles, one pixel per cycle, each with matching coordinates.
- Clear priority (macro defined):
  - `clear_start` and `req[1]` in the same cycle -> 19200 plots of colour 000 covering (0,0)..(159,119) in raster order, `clear_busy` high throughout, `req[1]` unacked;
  - then `clear_done` pulses, with `ack[1]` in that cycle.
- Reset mid-clear: assert `reset` at pixel (50,30) -> outputs return to reset values, no `clear_done`, `clear_busy=0`.
- Macro undefined: pulse `clear_start` -> `clear_busy`/`clear_done` stay 0 and requests continue to be acked normally.
